// File: rtl/game_sequencer_if.sv
// Bus between the game sequencer and the rest of the VGA game.
// The master side is the sequencer. It receives keyboard and collision
// inputs and done handshakes, and it drives the object code, the
// request strobes and the status flags. The slave side is the
// environment: keyboard decode, collision detection, the position
// updaters and the drawing datapath.
interface game_sequencer_if #(
  parameter int IDX_W = 4
);

  logic             frame_tick;
  logic             space_pressed;
  logic             enter_pressed;
  logic             pause_pressed;
  logic             collide;
  logic             done_update;
  logic             done_draw;
  logic             done_erase;

  logic [IDX_W-1:0] object_to_draw;
  logic             plot_on_vga;
  logic             update_req;
  logic             draw_req;
  logic             erase;
  logic             detect_collide;
  logic             respawn;
  logic [3:0]       lives_left;
  logic             paused;
  logic             game_over;

  modport master (
    input  frame_tick,
    input  space_pressed,
    input  enter_pressed,
    input  pause_pressed,
    input  collide,
    input  done_update,
    input  done_draw,
    input  done_erase,
    output object_to_draw,
    output plot_on_vga,
    output update_req,
    output draw_req,
    output erase,
    output detect_collide,
    output respawn,
    output lives_left,
    output paused,
    output game_over
  );

  modport slave (
    output frame_tick,
    output space_pressed,
    output enter_pressed,
    output pause_pressed,
    output collide,
    output done_update,
    output done_draw,
    output done_erase,
    input  object_to_draw,
    input  plot_on_vga,
    input  update_req,
    input  draw_req,
    input  erase,
    input  detect_collide,
    input  respawn,
    input  lives_left,
    input  paused,
    input  game_over
  );

endinterface

// File: rtl/game_sequencer.sv
// Top-level game sequencer for the VGA game.
// Each frame runs erase -> collision check -> update every object ->
// draw every object -> wait for the next frame tick. Objects are visited
// in the order player, enemy 0 .. enemy N-1. The sequencer issues one
// request at a time and waits for that request's done. It also handles
// pause, a lives counter with respawn, the start screen and the
// game-over screen.
module game_sequencer #(
  parameter int NUM_ENEMIES = 5,
  parameter int IDX_W       = 4,
  parameter int LIVES       = 3
) (
  input logic              clk,
  input logic              resetn,
  game_sequencer_if.master bus
);

  localparam logic [IDX_W-1:0] CODE_PLAYER   = IDX_W'(NUM_ENEMIES);
  localparam logic [IDX_W-1:0] CODE_START    = IDX_W'(NUM_ENEMIES + 1);
  localparam logic [IDX_W-1:0] CODE_GAMEOVER = IDX_W'(NUM_ENEMIES + 2);
  localparam logic [IDX_W-1:0] CODE_ERASE    = IDX_W'(NUM_ENEMIES + 3);
  localparam logic [IDX_W-1:0] LAST_ENEMY    = IDX_W'(NUM_ENEMIES - 1);
  localparam logic [IDX_W-1:0] FIRST_ENEMY   = '0;
  localparam logic [3:0]       LIVES_INIT    = 4'(LIVES);

  typedef enum logic [3:0] {
    S_DRAW_START,
    S_START_WAIT,
    S_ERASE,
    S_CHECK,
    S_RESPAWN,
    S_UPDATE,
    S_UGAP,
    S_DRAW,
    S_DGAP,
    S_FRAME_WAIT,
    S_GO_DRAW,
    S_GO_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_nextIdx;
  logic [3:0]       r_lives;
  logic [3:0]       w_nextLives;
  logic             r_paused;
  logic             w_nextPaused;

  logic             w_pauseToggled;
  logic             w_idxIsPlayer;
  logic             w_idxIsLast;
  logic [IDX_W-1:0] w_idxStep;

  logic [IDX_W-1:0] w_objectToDraw;
  logic             w_plotOnVga;
  logic             w_updateReq;
  logic             w_drawReq;
  logic             w_erase;
  logic             w_detectCollide;
  logic             w_respawn;
  logic             w_gameOver;

  // The object walk goes player first, then the enemies upward. The player
  // wraps to enemy 0; the last enemy ends the walk. The player test comes
  // first so a single-enemy game (player = 1, last = 0) still works.
  always_comb begin
    w_idxIsPlayer = (r_idx == CODE_PLAYER);
    w_idxIsLast   = (r_idx == LAST_ENEMY);
    w_idxStep     = w_idxIsPlayer ? FIRST_ENEMY : (r_idx + IDX_W'(1));
  end

  // State, object index, lives and pause flag. Reset returns to the start
  // screen from any point, even in the middle of a frame.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_DRAW_START;
      r_idx    <= CODE_PLAYER;
      r_lives  <= LIVES_INIT;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_idx    <= w_nextIdx;
      r_lives  <= w_nextLives;
      r_paused <= w_nextPaused;
    end
  end

  // Next-state logic and Moore output decode. A done strobe only counts
  // in the state that owns it. Pause is applied before the frame tick is
  // tested, so pausing blocks a tick in the same cycle and unpausing
  // accepts it.
  always_comb begin
    w_nextState     = r_state;
    w_nextIdx       = r_idx;
    w_nextLives     = r_lives;
    w_nextPaused    = r_paused;
    w_objectToDraw  = CODE_START;
    w_plotOnVga     = 1'b0;
    w_updateReq     = 1'b0;
    w_drawReq       = 1'b0;
    w_erase         = 1'b0;
    w_detectCollide = 1'b0;
    w_respawn       = 1'b0;
    w_gameOver      = 1'b0;
    w_pauseToggled  = r_paused ^ bus.pause_pressed;

    case (r_state)
      S_DRAW_START: begin
        w_drawReq      = 1'b1;
        w_plotOnVga    = 1'b1;
        w_objectToDraw = CODE_START;
        if (bus.done_draw) begin
          w_nextState = S_START_WAIT;
        end
      end

      S_START_WAIT: begin
        if (bus.space_pressed) begin
          w_nextState = S_ERASE;
        end
      end

      S_ERASE: begin
        w_erase        = 1'b1;
        w_plotOnVga    = 1'b1;
        w_objectToDraw = CODE_ERASE;
        if (bus.done_erase) begin
          w_nextState = S_CHECK;
        end
      end

      S_CHECK: begin
        w_detectCollide = 1'b1;
        if (!bus.collide) begin
          w_nextIdx   = CODE_PLAYER;
          w_nextState = S_UPDATE;
        end else if (r_lives > 4'd1) begin
          w_nextLives = r_lives - 4'd1;
          w_nextState = S_RESPAWN;
        end else begin
          w_nextLives = 4'd0;
          w_nextState = S_GO_DRAW;
        end
      end

      S_RESPAWN: begin
        w_respawn   = 1'b1;
        w_nextState = S_ERASE;
      end

      S_UPDATE: begin
        w_updateReq    = 1'b1;
        w_objectToDraw = r_idx;
        if (bus.done_update) begin
          w_nextState = S_UGAP;
        end
      end

      S_UGAP: begin
        if (!w_idxIsPlayer && w_idxIsLast) begin
          w_nextIdx   = CODE_PLAYER;
          w_nextState = S_DRAW;
        end else begin
          w_nextIdx   = w_idxStep;
          w_nextState = S_UPDATE;
        end
      end

      S_DRAW: begin
        w_drawReq      = 1'b1;
        w_plotOnVga    = 1'b1;
        w_objectToDraw = r_idx;
        if (bus.done_draw) begin
          w_nextState = S_DGAP;
        end
      end

      S_DGAP: begin
        if (!w_idxIsPlayer && w_idxIsLast) begin
          w_nextIdx   = CODE_PLAYER;
          w_nextState = S_FRAME_WAIT;
        end else begin
          w_nextIdx   = w_idxStep;
          w_nextState = S_DRAW;
        end
      end

      S_FRAME_WAIT: begin
        w_nextPaused = w_pauseToggled;
        if (bus.frame_tick && !w_pauseToggled) begin
          w_nextState = S_ERASE;
        end
      end

      S_GO_DRAW: begin
        w_drawReq      = 1'b1;
        w_plotOnVga    = 1'b1;
        w_gameOver     = 1'b1;
        w_objectToDraw = CODE_GAMEOVER;
        if (bus.done_draw) begin
          w_nextState = S_GO_WAIT;
        end
      end

      S_GO_WAIT: begin
        w_gameOver = 1'b1;
        if (bus.enter_pressed) begin
          w_nextLives  = LIVES_INIT;
          w_nextPaused = 1'b0;
          w_nextState  = S_DRAW_START;
        end
      end

      default: begin
        w_nextIdx   = CODE_PLAYER;
        w_nextState = S_DRAW_START;
      end
    endcase
  end

  assign bus.object_to_draw = w_objectToDraw;
  assign bus.plot_on_vga    = w_plotOnVga;
  assign bus.update_req     = w_updateReq;
  assign bus.draw_req       = w_drawReq;
  assign bus.erase          = w_erase;
  assign bus.detect_collide = w_detectCollide;
  assign bus.respawn        = w_respawn;
  assign bus.game_over      = w_gameOver;
  assign bus.lives_left     = r_lives;
  assign bus.paused         = r_paused;

endmodule
